cam_capture_writer: RTL

//  Receives the OV7670 RGB565 byte stream (VSYNC/HREF/D[7:0]) on the camera pixel clock.

---
 rtl/cam_capture_writer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cam_capture_writer.sv
// OV7670 RGB565 byte-stream capture: packs byte pairs into RGB332 pixels and drives the
// write port of the frame buffer, one write per pixel, addressed y*SCREEN_WIDTH + x.
module cam_capture_writer #(
  parameter int unsigned SCREEN_WIDTH  = 176,
  parameter int unsigned SCREEN_HEIGHT = 144,
  parameter int unsigned ADDR_W        = 15
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CAP_EN,
  input  logic              CAM_VSYNC,
  input  logic              CAM_HREF,
  input  logic [7:0]        CAM_DATA,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              W_EN,
  output logic              CAP_ACTIVE,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR
);

  localparam int unsigned XW = $clog2(SCREEN_WIDTH + 1);
  localparam int unsigned YW = $clog2(SCREEN_HEIGHT + 1);
  localparam logic [XW-1:0]     XMax    = XW'(SCREEN_WIDTH);
  localparam logic [YW-1:0]     YMax    = YW'(SCREEN_HEIGHT);
  localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(SCREEN_WIDTH);

  typedef enum logic [1:0] {StWaitVsHi, StWaitVsLo, StCapture} state_e;

  state_e            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              phase_q, phase_d;
  logic [5:0]        hi_bits_q, hi_bits_d;
  logic              err_q, err_d;
  logic              href_q;
  logic [ADDR_W-1:0] w_addr_d;
  logic [7:0]        w_data_d;
  logic              w_en_d, frame_done_d, frame_err_d;
  logic              line_end, err_inc;
  logic [YW-1:0]     y_inc;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StWaitVsHi;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitVsHi: if (CAM_VSYNC) state_d = StWaitVsLo;
      StWaitVsLo: if (!CAM_VSYNC) state_d = CAP_EN ? StCapture : StWaitVsHi;
      StCapture:  if (CAM_VSYNC) state_d = StWaitVsLo;
      default:    state_d = StWaitVsHi;
    endcase
  end

  // Line-end bookkeeping is shared by the normal HREF fall and a fall coinciding with VSYNC.
  assign line_end = href_q & ~CAM_HREF;
  assign err_inc  = err_q | (line_end & (x_q < XMax));
  assign y_inc    = (line_end && (y_q < YMax)) ? y_q + YW'(1) : y_q;

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    row_base_d   = row_base_q;
    phase_d      = phase_q;
    hi_bits_d    = hi_bits_q;
    err_d        = err_q;
    w_addr_d     = W_ADDR;
    w_data_d     = W_DATA;
    w_en_d       = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      StWaitVsLo: begin
        if (!CAM_VSYNC && CAP_EN) begin
          x_d        = '0;
          y_d        = '0;
          row_base_d = '0;
          phase_d    = 1'b0;
          err_d      = 1'b0;
        end
      end
      StCapture: begin
        if (CAM_VSYNC) begin
          frame_done_d = 1'b1;
          frame_err_d  = err_inc | (y_inc != YMax);
        end else if (CAM_HREF) begin
          if (!phase_q) begin
            hi_bits_d = {CAM_DATA[7:5], CAM_DATA[2:0]};
            phase_d   = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((x_q < XMax) && (y_q < YMax)) begin
              w_en_d   = 1'b1;
              w_data_d = {hi_bits_q, CAM_DATA[4:3]};
              w_addr_d = row_base_q + ADDR_W'(x_q);
              x_d      = x_q + XW'(1);
            end
          end
        end else if (line_end) begin
          err_d   = err_inc;
          phase_d = 1'b0;
          x_d     = '0;
          if (y_q < YMax) begin
            y_d        = y_inc;
            row_base_d = row_base_q + RowStep;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q        <= '0;
      y_q        <= '0;
      row_base_q <= '0;
      phase_q    <= 1'b0;
      hi_bits_q  <= '0;
      err_q      <= 1'b0;
      href_q     <= 1'b0;
      W_ADDR     <= '0;
      W_DATA     <= '0;
      W_EN       <= 1'b0;
      CAP_ACTIVE <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      row_base_q <= row_base_d;
      phase_q    <= phase_d;
      hi_bits_q  <= hi_bits_d;
      err_q      <= err_d;
      href_q     <= CAM_HREF;
      W_ADDR     <= w_addr_d;
      W_DATA     <= w_data_d;
      W_EN       <= w_en_d;
      CAP_ACTIVE <= (state_d == StCapture);
      FRAME_DONE <= frame_done_d;
      FRAME_ERR  <= frame_err_d;
    end
  end

endmodule
